// File: rtl/if_id_front_end_if.sv
// Fetch/decode front-end bundle: fetch inputs, IF/ID register outputs, main control.
// Latency: none, this is wiring only.
// Backpressure: stall holds the IF/ID register and flush loads a bubble; there is no ready path.
interface if_id_front_end_if;
   // Fetch-side inputs and pipeline control
   logic [31:0] pc_count;
   logic [31:0] instr_if;
   logic        stall;
   logic        flush;
   // Fetch-stage and IF/ID register outputs
   logic [31:0] addp4_if;
   logic [31:0] instr_id;
   logic [31:0] addp4_id;
   // Main-control outputs for the ID/EX register
   logic        wr_en;
   logic        regdst;
   logic        pcsrc;
   logic [1:0]  aluop;
   logic        memtoreg;
   logic        mem_read;
   logic        memwrite;
   logic        alusrc;
   logic        jump;

   modport master (
      output pc_count, instr_if, stall, flush,
      input  addp4_if, instr_id, addp4_id,
      input  wr_en, regdst, pcsrc, aluop, memtoreg, mem_read, memwrite, alusrc, jump
   );

   modport slave (
      input  pc_count, instr_if, stall, flush,
      output addp4_if, instr_id, addp4_id,
      output wr_en, regdst, pcsrc, aluop, memtoreg, mem_read, memwrite, alusrc, jump
   );
endinterface

// File: rtl/if_id_front_end.sv
// PC+4 adder, IF/ID pipeline register and main-control decoder of the pipeline front end.
// Latency: addp4_if is combinational; instr_id/addp4_id lag by one cycle; controls decode instr_id combinationally.
// Backpressure: stall holds IF/ID, flush (which wins over stall) loads an all-zero bubble.
module if_id_front_end #(
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rst,
   if_id_front_end_if.slave  bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [DW-1:0] addp4;
   logic [DW-1:0] instr_d, instr_q;
   logic [DW-1:0] addp4_d, addp4_q;

   logic       wr_en, regdst, pcsrc, memtoreg, mem_read, memwrite, alusrc, jump;
   logic [1:0] aluop;

   // Fetch-stage incrementer; wraps modulo 2^DW with the carry discarded.
   assign addp4 = bus.pc_count + DW'(4);

   // Next IF/ID contents: a flush bubble beats a stall, which beats a normal load.
   always_comb begin
      instr_d = instr_q;
      addp4_d = addp4_q;
      if (bus.flush) begin
         instr_d = '0;
         addp4_d = '0;
      end else if (!bus.stall) begin
         instr_d = bus.instr_if;
         addp4_d = addp4;
      end
   end

   // IF/ID register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         addp4_q <= '0;
      end else begin
         instr_q <= instr_d;
         addp4_q <= addp4_d;
      end
   end

   // Main-control decode; an all-zero word is a bubble and must not look like an R-type write.
   always_comb begin
      wr_en    = 1'b0;
      regdst   = 1'b0;
      pcsrc    = 1'b0;
      aluop    = 2'b00;
      memtoreg = 1'b0;
      mem_read = 1'b0;
      memwrite = 1'b0;
      alusrc   = 1'b0;
      jump     = 1'b0;
      if (instr_q != '0) begin
         case (instr_q[31:26])
            OP_RTYPE: begin
               wr_en  = 1'b1;
               regdst = 1'b1;
               aluop  = 2'b10;
            end
            OP_LW: begin
               wr_en    = 1'b1;
               alusrc   = 1'b1;
               memtoreg = 1'b1;
               mem_read = 1'b1;
            end
            OP_SW: begin
               alusrc   = 1'b1;
               memwrite = 1'b1;
            end
            OP_BEQ: begin
               pcsrc = 1'b1;
               aluop = 2'b01;
            end
            OP_ADDI: begin
               wr_en  = 1'b1;
               alusrc = 1'b1;
            end
            OP_J: begin
               jump = 1'b1;
            end
            default: begin
               wr_en = 1'b0;
            end
         endcase
      end
   end

   assign bus.addp4_if = addp4;
   assign bus.instr_id = instr_q;
   assign bus.addp4_id = addp4_q;
   assign bus.wr_en    = wr_en;
   assign bus.regdst   = regdst;
   assign bus.pcsrc    = pcsrc;
   assign bus.aluop    = aluop;
   assign bus.memtoreg = memtoreg;
   assign bus.mem_read = mem_read;
   assign bus.memwrite = memwrite;
   assign bus.alusrc   = alusrc;
   assign bus.jump     = jump;

endmodule

// File: tb/tb_if_id_front_end.sv
// Scoreboard bench for if_id_front_end: directed plan followed by randomized traffic.
// Expected values come from a behavioural model of the IF/ID register and opcode table.
// Stimulus drives on the falling edge; the monitor checks 1 time unit after each rising edge.
module tb_if_id_front_end;

   logic clk;
   logic rst;

   if_id_front_end_if bus ();

   if_id_front_end #(.DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a4if;
      logic [31:0] instr;
      logic [31:0] a4id;
      logic [9:0]  ctl;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec;
   int   n_err;

   // Reference model state: what the IF/ID register should hold after each edge.
   logic [31:0] m_instr;
   logic [31:0] m_a4;

   // Control vector order: {wr_en, regdst, pcsrc, aluop[1:0], memtoreg, mem_read, memwrite, alusrc, jump}
   function automatic logic [9:0] ref_ctl(input logic [31:0] ins);
      logic [9:0] c;
      c = 10'd0;
      if (ins != 32'd0) begin
         case (ins[31:26])
            6'd0:  c = 10'b1_1_0_10_0_0_0_0_0;  // R-type
            6'd35: c = 10'b1_0_0_00_1_1_0_1_0;  // lw
            6'd43: c = 10'b0_0_0_00_0_0_1_1_0;  // sw
            6'd4:  c = 10'b0_0_1_01_0_0_0_0_0;  // beq
            6'd8:  c = 10'b1_0_0_00_0_0_0_1_0;  // addi
            6'd2:  c = 10'b0_0_0_00_0_0_0_0_1;  // j
            default: c = 10'd0;
         endcase
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and record what the DUT must show after the next edge.
   task automatic drive(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
      exp_t e;
      @(negedge clk);
      rst          = r;
      bus.pc_count = pc;
      bus.instr_if = ins;
      bus.stall    = st;
      bus.flush    = fl;
      if (r || fl) begin
         m_instr = 32'd0;
         m_a4    = 32'd0;
      end else if (!st) begin
         m_instr = ins;
         m_a4    = pc + 32'd4;
      end
      e.a4if  = pc + 32'd4;
      e.instr = m_instr;
      e.a4id  = m_a4;
      e.ctl   = ref_ctl(m_instr);
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle with a pending expectation is popped and compared.
   initial begin
      exp_t e;
      logic [9:0] ctl;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            ctl = {bus.wr_en, bus.regdst, bus.pcsrc, bus.aluop, bus.memtoreg,
                   bus.mem_read, bus.memwrite, bus.alusrc, bus.jump};
            chk("addp4_if", bus.addp4_if, e.a4if);
            chk("instr_id", bus.instr_id, e.instr);
            chk("addp4_id", bus.addp4_id, e.a4id);
            chk("controls", {22'd0, ctl}, {22'd0, e.ctl});
         end
      end
   end

   // Random instruction: mostly legal opcodes with random fields, some zeros and junk.
   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [7];
      logic [31:0] w;
      int k;
      ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4;
      ops[4] = 6'd8; ops[5] = 6'd2;  ops[6] = 6'd63;
      k = $urandom_range(0, 9);
      w = $urandom;
      if (k < 7)       w = {ops[k], w[25:0]};
      else if (k == 7) w = 32'd0;
      return w;
   endfunction

   logic [31:0] sweep [6];

   initial begin
      logic [31:0] pc;
      n_vec   = 0;
      n_err   = 0;
      m_instr = 32'd0;
      m_a4    = 32'd0;
      rst          = 1'b1;
      bus.pc_count = 32'd0;
      bus.instr_if = 32'd0;
      bus.stall    = 1'b0;
      bus.flush    = 1'b0;

      // Reset with a live instruction on the fetch port
      drive(1'b1, 32'h0000_0000, 32'h8C22_0004, 1'b0, 1'b0);
      // Load lw
      drive(1'b0, 32'h0000_0008, 32'h8C22_0004, 1'b0, 1'b0);
      // Decode sweep
      sweep[0] = 32'h0022_1820; sweep[1] = 32'hAC22_0004; sweep[2] = 32'h1022_0003;
      sweep[3] = 32'h2022_0005; sweep[4] = 32'h0800_0010; sweep[5] = 32'hFC00_0000;
      pc = 32'h0000_0010;
      foreach (sweep[i]) begin
         drive(1'b0, pc, sweep[i], 1'b0, 1'b0);
         pc = pc + 32'd4;
      end
      // Stall twice, then flush together with stall
      drive(1'b0, 32'h0000_0100, 32'h0022_1820, 1'b0, 1'b0);
      drive(1'b0, 32'h0000_0104, 32'h8C22_0004, 1'b1, 1'b0);
      drive(1'b0, 32'h0000_0108, 32'hAC22_0004, 1'b1, 1'b0);
      drive(1'b0, 32'h0000_010C, 32'h1022_0003, 1'b1, 1'b1);
      // PC wrap
      drive(1'b0, 32'hFFFF_FFFC, 32'h2022_0005, 1'b0, 1'b0);
      // Back-to-back stream
      for (int i = 0; i < 4; i++)
         drive(1'b0, 32'(i * 4), sweep[i], 1'b0, 1'b0);
      // Reset mid-operation while stalled
      drive(1'b1, 32'h0000_0040, 32'h2022_0005, 1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         drive($urandom_range(0, 29) == 0, rpc, rand_instr(),
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/if_id_front_end.md
Name: if_id_front_end

Overview:
- Front-end slice of the 5-stage MIPS-style pipeline.
- Computes PC+4 in the fetch stage and registers fetch outputs into the IF/ID pipeline register.
- Decodes the registered instruction's opcode into main-control signals for the ID/EX register.
- Sits between the program counter / instruction memory and the register bank / ID/EX register.

Parameters:
- DW, 32, datapath width (PC and instruction width); only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- pc_count  input  32  current PC from the program counter.
- instr_if  input  32  instruction fetched at pc_count.
- stall  input  1  1 = IF/ID holds its contents.
- flush  input  1  1 = IF/ID loads a bubble (all zero).
- addp4_if  output  32  pc_count + 4; combinational; feeds the PC mux.
- instr_id  output  32  registered instruction.
- addp4_id  output  32  registered PC+4.
- wr_en  output  1  register-file write enable.
- regdst  output  1  1 = destination is rd [15:11]; 0 = rt [20:16].
- pcsrc  output  1  branch (beq) indicator.
- aluop  output  2  ALU operation class.
- memtoreg  output  1  1 = writeback from memory.
- mem_read  output  1  data-memory read.
- memwrite  output  1  data-memory write.
- alusrc  output  1  1 = ALU B operand is the sign-extended immediate.
- jump  output  1  J-type jump.

Behaviour:
- addp4_if = pc_count + 32'd4. Purely combinational, modulo 2^32: 0xFFFFFFFC -> 0x00000000, no carry out.
- IF/ID register updates on the rising edge of clk. Priority: rst > flush > stall > load.
  - rst=1: instr_id = 0, addp4_id = 0.
  - flush=1: instr_id = 0, addp4_id = 0.
  - stall=1: both registers hold their values.
  - Otherwise: instr_id <= instr_if, addp4_id <= addp4_if.
- Latency: one cycle from instr_if/pc_count to instr_id/addp4_id.
- Controller is combinational from instr_id[31:26]. Control outputs carry no extra register; the ID/EX register latches them downstream.
- Opcode decode, listing only signals that are 1 (all others 0; aluop given explicitly):
  - 000000 R-type: wr_en, regdst; aluop=10.
  - 100011 lw: wr_en, alusrc, memtoreg, mem_read; aluop=00.
  - 101011 sw: alusrc, memwrite; aluop=00.
  - 000100 beq: pcsrc; aluop=01.
  - 001000 addi: wr_en, alusrc; aluop=00.
  - 000010 j: jump; aluop=00.
  - Any other opcode: all controls 0, aluop=00 (treated as NOP).
- instr_id == 32'h00000000 (reset, flush bubble, or NOP) drives all control outputs 0. This overrides the R-type row so bubbles never write the register file.
- Consequence of the bubble rule: after rst, all control outputs are 0 and stay 0 until the first valid instruction is loaded.
- Reset mid-operation: pipeline contents are discarded on the next edge, with no partial update.
- stall and flush both asserted: flush wins.
- No X propagation: every output is defined for every input combination.

Test Plan:
- Reset: rst=1 for 1 edge with instr_if=0x8C220004 -> instr_id=0, addp4_id=0, all controls 0. addp4_if = pc_count+4 regardless of reset.
- Load lw: pc_count=0x00000008, instr_if=0x8C220004, one edge -> instr_id=0x8C220004, addp4_id=0x0000000C. Controls: wr_en=1, alusrc=1, memtoreg=1, mem_read=1, aluop=00, others 0.
- Decode sweep: load 0x00221820 (R-type), 0xAC220004 (sw), 0x10220003 (beq), 0x20220005 (addi), 0x08000010 (j), 0xFC000000 (illegal). Each must match the decode rows exactly; illegal -> all 0.
- Stall/flush: load an R-type instruction, then stall=1 for 2 edges with a new instr_if -> instr_id unchanged. Then flush=1 with stall=1 -> instr_id=0 and all controls 0.
- Wrap: pc_count=0xFFFFFFFC -> addp4_if=0x00000000, and addp4_id=0 after the edge.
- Back-to-back: stream 4 instructions with PCs 0, 4, 8, C -> each appears in instr_id exactly one cycle later, with addp4_id = PC+4.
